// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single data-RAM port.
//
// Requester 0 is the CPU MAR/MBR path (read or write), requester 1 is the
// debug memory reader (read only). The CPU has fixed priority, but a debug
// request refused for MAX_WAIT consecutive cycles wins the next arbitration.
// Only one access is outstanding at a time:
//   IDLE -> ACCESS -> IDLE                          (write, 2 cycles)
//   IDLE -> ACCESS -> RD_WAIT x RD_LAT -> RESP -> IDLE   (read, RD_LAT+3 cycles)
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_cpu_req/we/addr/wdata         CPU request, held until o_cpu_gnt
//   o_cpu_gnt, o_cpu_rvalid         one-cycle grant / read-data-valid pulses
//   o_cpu_rdata                     CPU read data, held until the next CPU read
//   i_dbg_req/addr                  debug read request, held until o_dbg_gnt
//   o_dbg_gnt, o_dbg_rvalid         one-cycle grant / read-data-valid pulses
//   o_dbg_rdata                     debug read data, held until the next debug read
//   o_ram_we/re/addr/wdata          RAM strobes and buses (strobes only in ACCESS)
//   i_ram_rdata                     RAM read data, valid RD_LAT cycles after o_ram_re
//   o_busy                          high whenever the FSM is not idle
// All outputs are registered and reset to zero.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_dbg_req,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic              o_dbg_gnt,
    output logic              o_dbg_rvalid,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_ram_we,
    output logic              o_ram_re,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_busy
);

    localparam int unsigned      WaitW   = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);
    // RD_LAT is limited to 1..3, so a 2-bit down-counter suffices.
    localparam logic [1:0]       LatLast = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StRdWait, StResp} state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;     // 0 = CPU, 1 = debug
    logic               we_q, we_d;
    logic [1:0]         lat_cnt_q, lat_cnt_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic               cpu_gnt_q, cpu_gnt_d;
    logic               dbg_gnt_q, dbg_gnt_d;
    logic               cpu_rvalid_q, cpu_rvalid_d;
    logic               dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]  dbg_rdata_q, dbg_rdata_d;
    logic               ram_we_q, ram_we_d;
    logic               ram_re_q, ram_re_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
    logic               busy_q, busy_d;
    logic               dbg_win;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        lat_cnt_d    = lat_cnt_q;
        cpu_gnt_d    = 1'b0;
        dbg_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        ram_we_d     = 1'b0;
        ram_re_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        dbg_win      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_cpu_req || i_dbg_req) begin
                    // Debug wins when alone, or when it has been starved long enough.
                    dbg_win     = i_dbg_req && (!i_cpu_req || (wait_cnt_q >= WaitMax));
                    owner_d     = dbg_win;
                    we_d        = !dbg_win && i_cpu_we;
                    ram_addr_d  = dbg_win ? i_dbg_addr : i_cpu_addr;
                    ram_wdata_d = dbg_win ? '0 : i_cpu_wdata;
                    cpu_gnt_d   = !dbg_win;
                    dbg_gnt_d   = dbg_win;
                    ram_we_d    = we_d;
                    ram_re_d    = !we_d;
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                if (we_q) begin
                    state_d = StIdle;
                end else begin
                    lat_cnt_d = LatLast;
                    state_d   = StRdWait;
                end
            end
            StRdWait: begin
                if (lat_cnt_q == 2'd0) begin
                    if (owner_q) begin
                        dbg_rdata_d  = i_ram_rdata;
                        dbg_rvalid_d = 1'b1;
                    end else begin
                        cpu_rdata_d  = i_ram_rdata;
                        cpu_rvalid_d = 1'b1;
                    end
                    state_d = StResp;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);

        // Starvation counter: refused debug cycles, cleared on grant (decision
        // or grant-pulse cycle) or when debug is not requesting.
        if (!i_dbg_req || dbg_win || dbg_gnt_q) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitMax) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            lat_cnt_q    <= 2'd0;
            wait_cnt_q   <= '0;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            ram_we_q     <= 1'b0;
            ram_re_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            lat_cnt_q    <= lat_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dbg_gnt_q    <= dbg_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            ram_we_q     <= ram_we_d;
            ram_re_q     <= ram_re_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign o_cpu_gnt    = cpu_gnt_q;
    assign o_dbg_gnt    = dbg_gnt_q;
    assign o_cpu_rvalid = cpu_rvalid_q;
    assign o_dbg_rvalid = dbg_rvalid_q;
    assign o_cpu_rdata  = cpu_rdata_q;
    assign o_dbg_rdata  = dbg_rdata_q;
    assign o_ram_we     = ram_we_q;
    assign o_ram_re     = ram_re_q;
    assign o_ram_addr   = ram_addr_q;
    assign o_ram_wdata  = ram_wdata_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// every cycle checked against a schedule-based reference model.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned RD_LAT   = 1;
    localparam int unsigned MAX_WAIT = 4;
    localparam int          MemSize  = 2 ** ADDR_W;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_cpu_req;
    logic              i_cpu_we;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [DATA_W-1:0] i_cpu_wdata;
    logic              o_cpu_gnt;
    logic              o_cpu_rvalid;
    logic [DATA_W-1:0] o_cpu_rdata;
    logic              i_dbg_req;
    logic [ADDR_W-1:0] i_dbg_addr;
    logic              o_dbg_gnt;
    logic              o_dbg_rvalid;
    logic [DATA_W-1:0] o_dbg_rdata;
    logic              o_ram_we;
    logic              o_ram_re;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_wdata;
    logic [DATA_W-1:0] i_ram_rdata;
    logic              o_busy;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RD_LAT  (RD_LAT),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cpu_req   (i_cpu_req),
        .i_cpu_we    (i_cpu_we),
        .i_cpu_addr  (i_cpu_addr),
        .i_cpu_wdata (i_cpu_wdata),
        .o_cpu_gnt   (o_cpu_gnt),
        .o_cpu_rvalid(o_cpu_rvalid),
        .o_cpu_rdata (o_cpu_rdata),
        .i_dbg_req   (i_dbg_req),
        .i_dbg_addr  (i_dbg_addr),
        .o_dbg_gnt   (o_dbg_gnt),
        .o_dbg_rvalid(o_dbg_rvalid),
        .o_dbg_rdata (o_dbg_rdata),
        .o_ram_we    (o_ram_we),
        .o_ram_re    (o_ram_re),
        .o_ram_addr  (o_ram_addr),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (i_ram_rdata),
        .o_busy      (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [DATA_W-1:0] ram_init(input int a);
        if (a == 5) return 16'h1234;
        return DATA_W'(a * 257) ^ 16'h5A5A;
    endfunction

    // RAM behavioural model with RD_LAT-cycle read pipeline.
    logic [DATA_W-1:0] ram     [MemSize];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    logic              ram_init_done = 1'b0;

    always @(posedge i_clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < MemSize; i++) ram[i] <= ram_init(i);
            ram_init_done <= 1'b1;
        end else if (o_ram_we) begin
            ram[o_ram_addr] <= o_ram_wdata;
        end
        rd_pipe[0] <= o_ram_re ? ram[o_ram_addr] : 'x;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign i_ram_rdata = rd_pipe[RD_LAT-1];

    // Reference model: event schedule derived from the grant/latency rules.
    logic [DATA_W-1:0] mm [MemSize];
    int                cyc, m_idle_at, m_gnt_at, m_rv_at, m_wait;
    bit                m_owner, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rv_data, m_cpu_rdata, m_dbg_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cpu_gnt"},    32'(o_cpu_gnt),    32'd0);
        chk({tag, "_dbg_gnt"},    32'(o_dbg_gnt),    32'd0);
        chk({tag, "_cpu_rvalid"}, 32'(o_cpu_rvalid), 32'd0);
        chk({tag, "_dbg_rvalid"}, 32'(o_dbg_rvalid), 32'd0);
        chk({tag, "_cpu_rdata"},  32'(o_cpu_rdata),  32'd0);
        chk({tag, "_dbg_rdata"},  32'(o_dbg_rdata),  32'd0);
        chk({tag, "_ram_we"},     32'(o_ram_we),     32'd0);
        chk({tag, "_ram_re"},     32'(o_ram_re),     32'd0);
        chk({tag, "_ram_addr"},   32'(o_ram_addr),   32'd0);
        chk({tag, "_ram_wdata"},  32'(o_ram_wdata),  32'd0);
        chk({tag, "_busy"},       32'(o_busy),       32'd0);
    endtask

    task automatic model_reset();
        m_idle_at   = 0;
        m_gnt_at    = -1;
        m_rv_at     = -1;
        m_wait      = 0;
        m_cpu_rdata = '0;
        m_dbg_rdata = '0;
    endtask

    // Advance one clock: model decides on current inputs, then the DUT outputs
    // of the new cycle are compared against the schedule.
    task automatic step();
        bit dbg_now;
        bit gc, rv;
        dbg_now = (cyc == m_gnt_at) && m_owner;
        if (cyc >= m_idle_at && (i_cpu_req || i_dbg_req)) begin
            m_owner  = i_dbg_req && (!i_cpu_req || m_wait >= int'(MAX_WAIT));
            m_we     = !m_owner && i_cpu_we;
            m_addr   = m_owner ? i_dbg_addr : i_cpu_addr;
            m_wdata  = i_cpu_wdata;
            m_gnt_at = cyc + 1;
            if (m_we) begin
                mm[m_addr] = m_wdata;
                m_rv_at    = -1;
                m_idle_at  = cyc + 2;
            end else begin
                m_rv_data  = mm[m_addr];
                m_rv_at    = cyc + int'(RD_LAT) + 2;
                m_idle_at  = cyc + int'(RD_LAT) + 3;
            end
            dbg_now = dbg_now || m_owner;
        end
        if (!i_dbg_req || dbg_now) m_wait = 0;
        else if (m_wait < int'(MAX_WAIT)) m_wait++;

        @(posedge i_clk);
        #1;
        cyc++;
        if (cyc == m_rv_at) begin
            if (m_owner) m_dbg_rdata = m_rv_data;
            else         m_cpu_rdata = m_rv_data;
        end
        gc = (cyc == m_gnt_at);
        rv = (cyc == m_rv_at);
        chk("cpu_gnt",    32'(o_cpu_gnt),    32'(gc && !m_owner));
        chk("dbg_gnt",    32'(o_dbg_gnt),    32'(gc && m_owner));
        chk("ram_we",     32'(o_ram_we),     32'(gc && m_we));
        chk("ram_re",     32'(o_ram_re),     32'(gc && !m_we));
        if (gc) chk("ram_addr", 32'(o_ram_addr), 32'(m_addr));
        if (gc && m_we) chk("ram_wdata", 32'(o_ram_wdata), 32'(m_wdata));
        chk("cpu_rvalid", 32'(o_cpu_rvalid), 32'(rv && !m_owner));
        chk("dbg_rvalid", 32'(o_dbg_rvalid), 32'(rv && m_owner));
        chk("cpu_rdata",  32'(o_cpu_rdata),  32'(m_cpu_rdata));
        chk("dbg_rdata",  32'(o_dbg_rdata),  32'(m_dbg_rdata));
        chk("busy",       32'(o_busy),       32'(cyc < m_idle_at));
    endtask

    task automatic drain();
        repeat (RD_LAT + 4) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cpu_before;
        int t0;
        bit got;

        i_rst_n     = 1'b0;
        i_cpu_req   = 1'b0;
        i_cpu_we    = 1'b0;
        i_cpu_addr  = '0;
        i_cpu_wdata = '0;
        i_dbg_req   = 1'b0;
        i_dbg_addr  = '0;
        cyc         = 0;
        for (int i = 0; i < MemSize; i++) mm[i] = ram_init(i);
        model_reset();
        #3;
        chk_all_zero("reset");
        #9;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // CPU write 0x12 <- 0xBEEF
        i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 8'h12; i_cpu_wdata = 16'hBEEF;
        step();
        chk("wr_gnt",   32'(o_cpu_gnt),   32'd1);
        chk("wr_we",    32'(o_ram_we),    32'd1);
        chk("wr_addr",  32'(o_ram_addr),  32'h12);
        chk("wr_wdata", 32'(o_ram_wdata), 32'hBEEF);
        i_cpu_req = 1'b0;
        step();
        chk("wr_idle_busy", 32'(o_busy), 32'd0);
        step();

        // CPU read 0x12 returns the written value at T+2
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 8'h12;
        step();
        chk("rd_gnt", 32'(o_cpu_gnt), 32'd1);
        i_cpu_req = 1'b0;
        step();
        step();
        chk("rd_rvalid",     32'(o_cpu_rvalid), 32'd1);
        chk("rd_rdata",      32'(o_cpu_rdata),  32'hBEEF);
        chk("rd_dbg_rdata0", 32'(o_dbg_rdata),  32'd0);
        step();

        // Debug read 0x05
        i_dbg_req = 1'b1; i_dbg_addr = 8'h05;
        step();
        chk("dbg_gnt_re", 32'(o_dbg_gnt && o_ram_re && !o_ram_we), 32'd1);
        i_dbg_req = 1'b0;
        step();
        step();
        chk("dbg_rvalid", 32'(o_dbg_rvalid), 32'd1);
        chk("dbg_rdata",  32'(o_dbg_rdata),  32'h1234);
        step();

        // Starvation guard: CPU back-to-back writes with debug held
        i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 8'h40; i_cpu_wdata = 16'h0001;
        i_dbg_req = 1'b1; i_dbg_addr = 8'h21;
        cpu_before = 0;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            step();
            if (o_dbg_gnt) begin
                got = 1'b1;
                i_dbg_req = 1'b0;
            end else if (o_cpu_gnt) begin
                cpu_before++;
                i_cpu_addr  = ADDR_W'($urandom_range(64, 79));
                i_cpu_wdata = DATA_W'($urandom());
            end
        end
        chk("starve_dbg_won",     32'(got),        32'd1);
        chk("starve_cpu_grants",  32'(cpu_before), 32'd2);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (o_cpu_gnt || o_dbg_gnt) begin
                got = 1'b1;
                chk("starve_next_is_cpu", 32'(o_cpu_gnt), 32'd1);
            end
        end
        chk("starve_next_seen", 32'(got), 32'd1);
        i_cpu_req = 1'b0;
        drain();

        // Simultaneous first-cycle requests: CPU first, debug at next IDLE
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 8'h12;
        i_dbg_req = 1'b1; i_dbg_addr = 8'h05;
        step();
        chk("sim_cpu_first", 32'({o_cpu_gnt, o_dbg_gnt}), 32'b10);
        i_cpu_req = 1'b0;
        t0 = cyc;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (o_dbg_gnt) got = 1'b1;
        end
        chk("sim_dbg_seen", 32'(got), 32'd1);
        chk("sim_dbg_delay", 32'(cyc - t0), 32'(RD_LAT + 3));
        i_dbg_req = 1'b0;
        drain();

        // Asynchronous reset during RD_WAIT of a CPU read
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 8'h12;
        step();
        i_cpu_req = 1'b0;
        step();
        chk("rst_in_rdwait_busy", 32'(o_busy), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        repeat (RD_LAT + 3) step();
        i_cpu_req = 1'b1; i_cpu_addr = 8'h05;
        step();
        i_cpu_req = 1'b0;
        step();
        step();
        chk("rst_fresh_rvalid", 32'(o_cpu_rvalid), 32'd1);
        chk("rst_fresh_rdata",  32'(o_cpu_rdata),  32'h1234);
        step();

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            if (o_cpu_gnt) i_cpu_req = 1'b0;
            if (o_dbg_gnt) i_dbg_req = 1'b0;
            if (!i_cpu_req && ($urandom_range(0, 2) == 0)) begin
                i_cpu_req   = 1'b1;
                i_cpu_we    = 1'($urandom_range(0, 1));
                i_cpu_addr  = ADDR_W'($urandom_range(0, 15));
                i_cpu_wdata = DATA_W'($urandom());
            end
            if (!i_dbg_req && ($urandom_range(0, 3) == 0)) begin
                i_dbg_req  = 1'b1;
                i_dbg_addr = ADDR_W'($urandom_range(0, 15));
            end
            step();
        end
        i_cpu_req = 1'b0;
        i_dbg_req = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-RAM port (address bus, data bus, read/write strobes) between two requesters: the CPU MAR/MBR path (requester 0) and a user-interface debug reader (requester 1) used to dump data memory while the CPU is stopped or single-stepping.
- Fixed priority to the CPU, plus a starvation guard for the debug reader.
- One outstanding access at a time, with a req/gnt/rvalid handshake.
- Sits between the external bus and DATA_RAM.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 16, data width.
- RD_LAT, 1, RAM read latency in cycles from the read-strobe cycle to valid i_ram_rdata (1..3).
- MAX_WAIT, 4, consecutive refused debug-request cycles after which the debug reader wins one arbitration.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cpu_req  in  1  CPU access request, held until o_cpu_gnt
- i_cpu_we  in  1  1 = write, 0 = read
- i_cpu_addr  in  ADDR_W  CPU address
- i_cpu_wdata  in  DATA_W  CPU write data
- o_cpu_gnt  out  1  one-cycle grant pulse
- o_cpu_rvalid  out  1  one-cycle read-data-valid pulse
- o_cpu_rdata  out  DATA_W  CPU read data
- i_dbg_req  in  1  debug read request, held until o_dbg_gnt
- i_dbg_addr  in  ADDR_W  debug address
- o_dbg_gnt  out  1  one-cycle grant pulse
- o_dbg_rvalid  out  1  one-cycle read-data-valid pulse
- o_dbg_rdata  out  DATA_W  debug read data
- o_ram_we  out  1  RAM write strobe
- o_ram_re  out  1  RAM read strobe
- o_ram_addr  out  ADDR_W  RAM address
- o_ram_wdata  out  DATA_W  RAM write data
- i_ram_rdata  in  DATA_W  RAM read data
- o_busy  out  1  high whenever state is not IDLE

Behaviour:
- Clocking: i_clk is the only clock; i_rst_n is asynchronous active-low. All outputs are registered.
- Reset value of every output is 0, including the rdata registers; wait_cnt = 0; state = IDLE.
- States:
  - IDLE: samples requests.
  - ACCESS: one cycle with strobes asserted.
  - RD_WAIT: RD_LAT cycles.
  - RESP: one cycle, rvalid.
- IDLE, no request: remain in IDLE.
- IDLE with a request: the winner is latched (owner, we, addr, wdata) and the FSM moves to ACCESS.
- ACCESS cycle outputs:
  - the owner's gnt = 1;
  - o_ram_addr/o_ram_wdata driven from the latched values;
  - o_ram_we = we, o_ram_re = !we.
- Grant latency: grant appears 1 cycle after the request is first sampled in IDLE.
- ACCESS transitions: a write returns to IDLE; a read goes to RD_WAIT.
- RD_WAIT: counts RD_LAT cycles. In the last RD_WAIT cycle, i_ram_rdata is captured into the owner's rdata register; next state is RESP.
- RESP: the owner's rvalid = 1 for one cycle, then IDLE. The rvalid cycle is ACCESS + RD_LAT + 1.
- rdata registers hold their value until the next read by the same requester. The other requester's rdata is never modified.
- Requesters must keep req and request fields stable until gnt. Request fields are sampled only in IDLE. The requester may drop req in the gnt cycle.
- A request withdrawn before being sampled is ignored, with no side effects.
- Arbitration in IDLE:
  - CPU only → CPU.
  - Debug only → debug.
  - Both requesting → CPU, unless wait_cnt ≥ MAX_WAIT, in which case debug wins.
- wait_cnt:
  - increments (saturating at MAX_WAIT) each cycle in which i_dbg_req = 1 and debug is not granted, including busy cycles;
  - clears on debug grant or when i_dbg_req = 0.
- Debug writes are impossible: no debug we port exists.
- RAM strobes are never asserted outside ACCESS. At most one strobe is high at a time.
- Outstanding-access rule: no new grant while in ACCESS, RD_WAIT or RESP. Requests arriving then are held by their requesters and arbitrated in the next IDLE.
- Asynchronous reset mid-access: outputs drop to 0 immediately, the pending read is discarded, and no rvalid is ever issued for it.
- Throughput: a write takes 2 cycles (IDLE + ACCESS); a read takes RD_LAT + 3 cycles.

Test Plan:
- CPU write, addr 0x12, data 0xBEEF → ACCESS 1 cycle after the request: o_ram_we = 1, o_ram_addr = 0x12, o_ram_wdata = 0xBEEF, o_cpu_gnt = 1. Back in IDLE the next cycle; no rvalid pulse.
- CPU read, addr 0x12, RAM returns 0xBEEF, RD_LAT = 1 → gnt at T, o_cpu_rvalid at T+2 with o_cpu_rdata = 0xBEEF. o_dbg_rdata stays 0.
- Debug read, addr 0x05, RAM returns 0x1234, no CPU traffic → o_dbg_gnt and o_ram_re = 1 in the same cycle; o_dbg_rvalid 2 cycles later with 0x1234. o_ram_we never asserted.
- CPU issues continuous back-to-back writes while i_dbg_req is held, MAX_WAIT = 4 → CPU is granted until wait_cnt reaches 4; the next IDLE grants debug; wait_cnt returns to 0. CPU is granted again afterwards.
- Simultaneous first-cycle requests with wait_cnt = 0 → CPU granted first; debug granted in the following IDLE.
- Reset asserted during RD_WAIT of a CPU read → all outputs 0 at once. After release, o_cpu_rvalid stays 0 and a fresh read completes normally.
